ofdm_cp_sequencer: RTL and testbench
====================================

Name: ofdm_cp_sequencer

Overview:
Read-side controller for the OFDM cyclic-prefix insertion path. It tracks two ping-pong symbol banks filled by the upstream writer. For each full bank it issues a command stream (bank, address, mux channel, sop/eop): first the CP tail, then the full symbol body. The symbol-buffer datapath and the output multiplexer consume this stream through a valid/ready handshake.

Parameters:
NFFT, 64, samples per OFDM symbol (power of two)
ADDR_W, 6, log2(NFFT)
CP_DEFAULT, 16, CP length loaded at reset into the config register

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
wr_done  in  1  one-cycle pulse: writer finished filling the current write bank
wr_ready  out  1  a bank is free for writing (credit count < 2)
cfg_cp_len  in  ADDR_W+1  requested CP length in samples
cfg_load  in  1  latch cfg_cp_len into the config register
cmd_valid  out  1  command valid
cmd_ready  in  1  downstream accepts the command
cmd_bank  out  1  bank to read
cmd_addr  out  ADDR_W  sample address within the bank
cmd_channel  out  2  mux select: 0 = CP segment, 1 = body segment
cmd_sop  out  1  first command of the output symbol
cmd_eop  out  1  last command of the output symbol
ovf_err  out  1  sticky flag: wr_done received with both banks full
sym_count  out  16  count of completed output symbols (wraps)

Behaviour:
- Reset values: cmd_valid=0, cmd_bank=0, cmd_addr=0, cmd_channel=0, cmd_sop=0, cmd_eop=0, ovf_err=0, sym_count=0; credit count=0, so wr_ready=1; cfg register=CP_DEFAULT; state=IDLE.
- Reset mid-symbol: immediately abandons the symbol. No eop is issued and all credits are cleared.
- All cmd_* outputs are registered.
- Handshake: a transfer occurs when cmd_valid && cmd_ready. While cmd_valid=1 and cmd_ready=0, every cmd_* output holds stable.
- Credit counter (0..2):
  - +1 on wr_done.
  - −1 on the accepted command that carries cmd_eop.
  - Both on the same cycle: no change.
  - wr_done when count=2 and no release that cycle: ignored and ovf_err is set. ovf_err clears only on reset.
- cfg_load: loads cfg_cp_len, clamped to NFFT if larger. It takes effect only at the next symbol start; the symbol in progress is unaffected.
- State IDLE (cmd_valid=0):
  - If count≠0: latch cp = cfg register.
  - If cp≠0: go to CP with addr = NFFT−cp, channel 0.
  - If cp=0: go to BODY with addr 0, channel 1.
  - In both cases assert cmd_valid and cmd_sop on the next cycle.
  - Latency: wr_done sampled at edge t, count=1 after t, first command valid after edge t+1.
- State CP (channel 0):
  - Each accepted command increments addr.
  - On acceptance at addr NFFT−1: go to BODY with addr 0, channel 1.
  - sop is asserted only on the first command of the symbol.
- State BODY (channel 1):
  - Each acceptance increments addr.
  - cmd_eop=1 when addr=NFFT−1.
  - On eop acceptance: toggle cmd_bank, increment sym_count, release one credit.
  - If the post-release count≠0: go directly to the next symbol start, with no bubble (next cycle valid, sop=1, new cp latched).
  - Otherwise go to IDLE with cmd_valid=0.
- Commands per symbol = cp + NFFT. Addresses wrap only via the explicit state transition; counters are ADDR_W wide and never free-run.
- cp=NFFT: CP segment covers addresses 0..NFFT−1 (a full symbol repeat).
- wr_ready = (count<2), combinational from the registered count.

Decomposition:
- Shared package ofdm_cp_pkg holds:
  - channel constants CH_CP=2'd0, CH_BODY=2'd1;
  - state enum {IDLE, CP, BODY};
  - NFFT/ADDR_W defaults.
- One natural sub-module, ofdm_bank_credit: the 0..2 credit counter with ovf_err and wr_ready.
- The state machine and address generation stay in the top module.

Test Plan:
- Single symbol, cp=16, cmd_ready=1:
  - one wr_done → 80 commands;
  - addr 48..63 ch0, then 0..63 ch1;
  - sop on the first, eop on the last;
  - bank 0, sym_count=1, wr_ready high throughout.
- Back-to-back: two wr_done 5 cycles apart → 160 consecutive valid commands with no gap; second symbol on bank 1; wr_ready low between the second wr_done and the first eop.
- Backpressure: cmd_ready toggling 1-0-1 with random stalls → outputs stable during stalls; address sequence identical to the first scenario.
- Config:
  - cfg_load cp=0 → 64 commands, all ch1, sop on addr 0.
  - cfg_load cp=80 → clamped to 64; 128 commands.
  - cfg_load mid-symbol → current symbol unchanged.
- Overflow: three wr_done with no eop accepted → ovf_err=1 and count stays 2. wr_done on the same cycle as an eop acceptance → count unchanged, no error.
- Reset asserted at the 30th command → next cycle cmd_valid=0, wr_ready=1, sym_count=0; a subsequent wr_done restarts at bank 0 with sop.

Source files
------------

// File: rtl/ofdm_cp_pkg.sv
// ofdm_cp_pkg
// Shared definitions for the OFDM cyclic-prefix read sequencer:
//   - default symbol geometry (NFFT, ADDR_W) and reset CP length
//   - mux channel encodings carried on cmd_channel
//   - sequencer state encoding
package ofdm_cp_pkg;

    localparam int NFFT_DEF   = 64;
    localparam int ADDR_W_DEF = 6;
    localparam int CP_DEF     = 16;

    localparam logic [1:0] CH_CP   = 2'd0;
    localparam logic [1:0] CH_BODY = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        BODY = 2'd2
    } state_e;

endpackage

// File: rtl/ofdm_cp_sequencer_credit.sv
// ofdm_bank_credit
// Tracks how many of the two ping-pong symbol banks hold a complete,
// not-yet-read symbol.
// Ports:
//   clk_clk       in   system clock
//   reset_reset   in   synchronous active-high reset
//   wr_done       in   writer finished a bank (+1 credit)
//   rel_credit    in   reader finished a bank (-1 credit)
//   credit_cnt    out  current credit count, 0..2
//   wr_ready      out  a bank is free for the writer
//   ovf_err       out  sticky: wr_done arrived with both banks full
module ofdm_bank_credit (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       wr_done,
    input  logic       rel_credit,
    output logic [1:0] credit_cnt,
    output logic       wr_ready,
    output logic       ovf_err
);

    logic [1:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        // Simultaneous fill and release cancel out, even when full.
        if (wr_done && !rel_credit) begin
            if (cnt_q == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end else if (!wr_done && rel_credit && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cnt_q <= 2'd0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign credit_cnt = cnt_q;
    assign wr_ready   = (cnt_q < 2'd2);
    assign ovf_err    = ovf_q;

endmodule

// File: rtl/ofdm_cp_sequencer.sv
// ofdm_cp_sequencer
// Read-side controller for cyclic-prefix insertion. For every filled bank
// it emits a command stream: the last cp samples of the symbol (channel
// CH_CP), then the whole symbol (channel CH_BODY).
// Ports:
//   clk_clk, reset_reset      clock, synchronous active-high reset
//   wr_done / wr_ready        writer handshake (bank filled / bank free)
//   cfg_cp_len / cfg_load     CP length configuration (clamped to NFFT)
//   cmd_valid / cmd_ready     command handshake to the datapath
//   cmd_bank, cmd_addr        bank and sample address to read
//   cmd_channel               output mux select
//   cmd_sop / cmd_eop         first / last command of an output symbol
//   ovf_err                   sticky writer-overrun flag
//   sym_count                 completed output symbols (wraps)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no full bank; cmd_valid low, waiting for a credit
// CP    | emitting prefix: addresses NFFT-cp .. NFFT-1, channel CP
// BODY  | emitting symbol: addresses 0 .. NFFT-1, channel BODY
module ofdm_cp_sequencer
    import ofdm_cp_pkg::*;
#(
    parameter int NFFT       = NFFT_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CP_DEFAULT = CP_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic [ADDR_W:0]   cfg_cp_len,
    input  logic              cfg_load,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_bank,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [1:0]        cmd_channel,
    output logic              cmd_sop,
    output logic              cmd_eop,
    output logic              ovf_err,
    output logic [15:0]       sym_count
);

    localparam logic [ADDR_W:0]   NFFT_W    = (ADDR_W+1)'(NFFT);
    localparam logic [ADDR_W:0]   CP_RST    = (ADDR_W+1)'(CP_DEFAULT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NFFT - 1);

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        chan_q, chan_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [15:0]       sym_q, sym_d;
    logic [ADDR_W:0]   cfg_q, cfg_d;

    logic              accept;
    logic              eop_accept;
    logic              start;
    logic [1:0]        credit_cnt;
    logic [ADDR_W:0]   cp_start;
    logic [ADDR_W-1:0] addr_inc;

    assign accept     = valid_q && cmd_ready;
    assign eop_accept = accept && eop_q && (state_q == BODY);
    assign addr_inc   = addr_q + ADDR_W'(1);
    // cp = NFFT wraps to start address 0, i.e. a full-symbol repeat.
    assign cp_start   = NFFT_W - cfg_q;

    ofdm_bank_credit u_credit (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .wr_done     (wr_done),
        .rel_credit  (eop_accept),
        .credit_cnt  (credit_cnt),
        .wr_ready    (wr_ready),
        .ovf_err     (ovf_err)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        chan_d  = chan_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        sym_d   = sym_q;
        cfg_d   = cfg_q;
        start   = 1'b0;

        // The register only feeds symbol starts, so a load mid-symbol
        // cannot disturb the symbol in flight.
        if (cfg_load) begin
            cfg_d = (cfg_cp_len > NFFT_W) ? NFFT_W : cfg_cp_len;
        end

        case (state_q)
            IDLE: begin
                if (credit_cnt != 2'd0) begin
                    start = 1'b1;
                end
            end
            CP: begin
                if (accept) begin
                    sop_d = 1'b0;
                    if (addr_q == ADDR_LAST) begin
                        state_d = BODY;
                        addr_d  = '0;
                        chan_d  = CH_BODY;
                    end else begin
                        addr_d = addr_inc;
                    end
                end
            end
            BODY: begin
                if (accept) begin
                    sop_d = 1'b0;
                    if (eop_q) begin
                        bank_d = ~bank_q;
                        sym_d  = sym_q + 16'd1;
                        // Credit remaining after this release (a same-cycle
                        // wr_done replaces the one being released).
                        if ((credit_cnt == 2'd2) || wr_done) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            eop_d   = 1'b0;
                        end
                    end else begin
                        addr_d = addr_inc;
                        eop_d  = (addr_inc == ADDR_LAST);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (start) begin
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
            if (cfg_q != '0) begin
                state_d = CP;
                addr_d  = cp_start[ADDR_W-1:0];
                chan_d  = CH_CP;
            end else begin
                state_d = BODY;
                addr_d  = '0;
                chan_d  = CH_BODY;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            bank_q  <= 1'b0;
            addr_q  <= '0;
            chan_q  <= CH_CP;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            sym_q   <= 16'd0;
            cfg_q   <= CP_RST;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            chan_q  <= chan_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            sym_q   <= sym_d;
            cfg_q   <= cfg_d;
        end
    end

    assign cmd_valid   = valid_q;
    assign cmd_bank    = bank_q;
    assign cmd_addr    = addr_q;
    assign cmd_channel = chan_q;
    assign cmd_sop     = sop_q;
    assign cmd_eop     = eop_q;
    assign sym_count   = sym_q;

endmodule

// File: tb/tb_ofdm_cp_sequencer.sv
// Directed bench for ofdm_cp_sequencer (NFFT=64).
module tb_ofdm_cp_sequencer;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        wr_done;
    logic        wr_ready;
    logic [6:0]  cfg_cp_len;
    logic        cfg_load;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_bank;
    logic [5:0]  cmd_addr;
    logic [1:0]  cmd_channel;
    logic        cmd_sop;
    logic        cmd_eop;
    logic        ovf_err;
    logic [15:0] sym_count;

    int total = 0;
    int bad   = 0;

    ofdm_cp_sequencer dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .wr_done     (wr_done),
        .wr_ready    (wr_ready),
        .cfg_cp_len  (cfg_cp_len),
        .cfg_load    (cfg_load),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_bank    (cmd_bank),
        .cmd_addr    (cmd_addr),
        .cmd_channel (cmd_channel),
        .cmd_sop     (cmd_sop),
        .cmd_eop     (cmd_eop),
        .ovf_err     (ovf_err),
        .sym_count   (sym_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic pulse_wr();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
    endtask

    task automatic load_cfg(input logic [6:0] v);
        cfg_cp_len = v;
        cfg_load   = 1'b1;
        step();
        cfg_load   = 1'b0;
    endtask

    // Drives cmd_ready and collects one output symbol of cp+64 commands,
    // checking each accepted command against the expected sequence.
    task automatic run_sym(input string tag, input int cp, input logic bank,
                           input int stall_pct, input int pulse_cyc,
                           input int cfg_cyc, input logic [6:0] cfg_val,
                           input bit in_stream, output int gaps, output int lows);
        int          n;
        int          cyc;
        bit          started;
        bit          held;
        logic        rdy;
        logic [10:0] held_v;
        logic [10:0] obs;
        logic [10:0] exp;
        logic [5:0]  a;
        n = 0; cyc = 0; started = in_stream; held = 1'b0; gaps = 0; lows = 0;
        held_v = '0;
        while (n < cp + 64 && cyc < 3000) begin
            wr_done    = (cyc == pulse_cyc);
            cfg_load   = (cyc == cfg_cyc);
            cfg_cp_len = cfg_val;
            obs = {cmd_bank, cmd_addr, cmd_channel, cmd_sop, cmd_eop};
            if (held) chk($sformatf("%s stall hold cyc%0d", tag, cyc), {21'd0, obs}, {21'd0, held_v});
            rdy = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            cmd_ready = rdy;
            if (!wr_ready) lows++;
            if (cmd_valid) started = 1'b1;
            else if (started) gaps++;
            held   = cmd_valid && !rdy;
            held_v = obs;
            if (cmd_valid && rdy) begin
                a   = (n < cp) ? 6'(64 - cp + n) : 6'(n - cp);
                exp = {bank, a, (n < cp) ? 2'd0 : 2'd1, (n == 0), (n == cp + 63)};
                chk($sformatf("%s cmd%0d", tag, n), {21'd0, obs}, {21'd0, exp});
                n++;
            end
            step();
            cyc++;
        end
        wr_done   = 1'b0;
        cfg_load  = 1'b0;
        cmd_ready = 1'b0;
        chk($sformatf("%s cmd count", tag), n, cp + 64);
    endtask

    initial begin
        int g;
        int l;
        int g2;
        int l2;
        int n;
        int cyc;

        reset_reset = 1'b1;
        wr_done     = 1'b0;
        cfg_cp_len  = 7'd0;
        cfg_load    = 1'b0;
        cmd_ready   = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;

        // Reset state
        chk("rst valid", cmd_valid, 0);
        chk("rst bundle", {cmd_bank, cmd_addr, cmd_channel, cmd_sop, cmd_eop}, 0);
        chk("rst ovf", ovf_err, 0);
        chk("rst sym", sym_count, 0);
        chk("rst wr_ready", wr_ready, 1);
        step();
        chk("idle valid", cmd_valid, 0);

        // Single symbol, cp=16, bank 0
        pulse_wr();
        chk("single latency", cmd_valid, 0);
        run_sym("single", 16, 1'b0, 0, -1, -1, 7'd0, 1'b0, g, l);
        chk("single gaps", g, 0);
        chk("single lows", l, 0);
        chk("single sym", sym_count, 1);
        chk("single idle", cmd_valid, 0);

        // Back-to-back: second wr_done 5 cycles after the first
        pulse_wr();
        run_sym("b2b0", 16, 1'b1, 0, 4, -1, 7'd0, 1'b0, g, l);
        run_sym("b2b1", 16, 1'b0, 0, -1, -1, 7'd0, 1'b1, g2, l2);
        chk("b2b gaps0", g, 0);
        chk("b2b lows0", l, 76);
        chk("b2b gaps1", g2, 0);
        chk("b2b lows1", l2, 0);
        chk("b2b sym", sym_count, 3);

        // Backpressure with random stalls
        pulse_wr();
        run_sym("stall", 16, 1'b1, 40, -1, -1, 7'd0, 1'b0, g, l);
        chk("stall gaps", g, 0);
        chk("stall sym", sym_count, 4);

        // cp = 0: body only
        load_cfg(7'd0);
        pulse_wr();
        run_sym("cp0", 0, 1'b0, 0, -1, -1, 7'd0, 1'b0, g, l);
        chk("cp0 sym", sym_count, 5);

        // cp = 80 clamps to 64
        load_cfg(7'd80);
        pulse_wr();
        run_sym("cp80", 64, 1'b1, 0, -1, -1, 7'd80, 1'b0, g, l);
        chk("cp80 sym", sym_count, 6);

        // Mid-symbol cfg_load affects only the following symbol
        load_cfg(7'd16);
        pulse_wr();
        run_sym("mid0", 16, 1'b0, 0, 10, 20, 7'd8, 1'b0, g, l);
        chk("mid lows0", l, 70);
        run_sym("mid1", 8, 1'b1, 0, -1, -1, 7'd8, 1'b1, g, l);
        chk("mid gaps1", g, 0);
        chk("mid sym", sym_count, 8);

        // wr_done coinciding with eop acceptance
        pulse_wr();
        run_sym("sim0", 8, 1'b0, 0, 72, -1, 7'd8, 1'b0, g, l);
        chk("sim lows0", l, 0);
        run_sym("sim1", 8, 1'b1, 0, -1, -1, 7'd8, 1'b1, g, l);
        chk("sim gaps1", g, 0);
        chk("sim ovf", ovf_err, 0);
        chk("sim sym", sym_count, 10);
        step();
        chk("sim idle", cmd_valid, 0);

        // Overflow: three wr_done with no acceptance
        cmd_ready = 1'b0;
        pulse_wr();
        step();
        pulse_wr();
        step();
        chk("ovf after2", ovf_err, 0);
        chk("ovf ready2", wr_ready, 0);
        pulse_wr();
        step();
        chk("ovf after3", ovf_err, 1);
        chk("ovf ready3", wr_ready, 0);
        chk("ovf held cmd", {cmd_valid, cmd_bank, cmd_addr, cmd_channel, cmd_sop, cmd_eop},
            {1'b1, 1'b0, 6'd56, 2'd0, 1'b1, 1'b0});
        run_sym("ovf0", 8, 1'b0, 0, -1, -1, 7'd8, 1'b1, g, l);
        chk("ovf lows0", l, 72);
        run_sym("ovf1", 8, 1'b1, 0, -1, -1, 7'd8, 1'b1, g, l);
        chk("ovf gaps1", g, 0);
        step();
        step();
        chk("ovf drained", cmd_valid, 0);
        chk("ovf ready end", wr_ready, 1);
        chk("ovf sticky", ovf_err, 1);
        chk("ovf sym", sym_count, 12);

        // Reset at the 30th command
        pulse_wr();
        cmd_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (!(cmd_valid && n == 29) && cyc < 300) begin
            if (cmd_valid) n++;
            step();
            cyc++;
        end
        chk("rst30 reached", n, 29);
        reset_reset = 1'b1;
        step();
        reset_reset = 1'b0;
        cmd_ready   = 1'b0;
        chk("rst30 valid", cmd_valid, 0);
        chk("rst30 wr_ready", wr_ready, 1);
        chk("rst30 sym", sym_count, 0);
        chk("rst30 ovf", ovf_err, 0);
        chk("rst30 eop", cmd_eop, 0);
        step();
        chk("rst30 no credit", cmd_valid, 0);
        pulse_wr();
        run_sym("restart", 16, 1'b0, 0, -1, -1, 7'd0, 1'b0, g, l);
        chk("restart sym", sym_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
